// File: rtl/ibuffer_loader.sv
`default_nettype none
// ============================================================================
// Module   : ibuffer_loader
// Purpose  : Upstream feeder for the 4-column input buffer of the 4x4 MAC
//            array. A START pulse fetches four 32-bit words from the input
//            SRAM at BASE_ADDR..BASE_ADDR+3 (address wraps mod 2^AW). Each
//            word is written into buffer columns 0..3, then START_CALC is
//            pulsed. DONE is pulsed after a fixed CALC_CYCLES compute window.
//
// Ports    : CLK, RSTN          - clock, asynchronous active-low reset
//            START              - request, only honoured while idle
//            BASE_ADDR, ODST_IN - latched on an accepted START
//            MEM_CS, MEM_ADDR   - SRAM read strobe / address (combinational)
//            MEM_RDATA          - SRAM read data, 1-cycle latency
//            LOAD_EN, ICOL      - buffer column write enable / column index
//            IWord              - buffer write word ([31:24] -> column-0 reg)
//            START_CALC         - one-cycle launch pulse to the buffer
//            ODST_OUT           - destination tag held for the operation
//            BUSY, DONE         - activity flag / one-cycle completion pulse
//
// Options  : `define ILOADER_BSWAP_EN to byte-reverse MEM_RDATA onto IWord
//            (for SRAM images stored little-endian per row). Timing is
//            unchanged.
//
// Revision : 1.0 - initial release
// ============================================================================
module ibuffer_loader #(
    parameter int AW          = 8,
    parameter int CALC_CYCLES = 7    // legal range 1..255
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic [AW-1:0] BASE_ADDR,
    input  logic [3:0]    ODST_IN,
    output logic          MEM_CS,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [31:0]   MEM_RDATA,
    output logic          LOAD_EN,
    output logic [1:0]    ICOL,
    output logic [31:0]   IWord,
    output logic          START_CALC,
    output logic [3:0]    ODST_OUT,
    output logic          BUSY,
    output logic          DONE
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_LAST  = 3'd2;
    localparam logic [2:0] c_KICK  = 3'd3;
    localparam logic [2:0] c_WAIT  = 3'd4;

    localparam logic [7:0] c_CALC  = 8'(CALC_CYCLES);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [AW-1:0] r_base;
    logic [1:0]    r_idx;
    logic [7:0]    r_cnt;
    logic [3:0]    r_odst;
    logic          r_load_en;
    logic [1:0]    r_icol;
    logic          r_done;
    logic          w_wait_end;

    // The wait window ends when the counter reaches 1, giving exactly
    // CALC_CYCLES cycles in WAIT (counter values CALC_CYCLES..1).
    assign w_wait_end = (r_state == c_WAIT) && (r_cnt == 8'd1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= c_IDLE;
            r_base  <= '0;
            r_idx   <= 2'd0;
            r_cnt   <= 8'd0;
            r_odst  <= 4'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (START) begin
                        r_base <= BASE_ADDR;
                        r_odst <= ODST_IN;
                        r_idx  <= 2'd0;
                    end
                end
                // Index wraps back to 0 after the fourth fetch.
                c_FETCH: r_idx <= r_idx + 2'd1;
                c_KICK:  r_cnt <= c_CALC;
                c_WAIT:  r_cnt <= r_cnt - 8'd1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (START) w_next = c_FETCH;
            c_FETCH: if (r_idx == 2'd3) w_next = c_LAST;
            c_LAST:  w_next = c_KICK;
            c_KICK:  w_next = c_WAIT;
            c_WAIT:  if (w_wait_end) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        MEM_CS     = 1'b0;
        MEM_ADDR   = '0;
        START_CALC = 1'b0;
        BUSY       = (r_state != c_IDLE);
        case (r_state)
            c_FETCH: begin
                MEM_CS   = 1'b1;
                // Natural AW-bit overflow gives the wrap past all-ones.
                MEM_ADDR = r_base + {{(AW-2){1'b0}}, r_idx};
            end
            c_KICK:  START_CALC = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Write-side pipeline: one cycle behind the SRAM strobe so the write
    // lines up with the SRAM's read latency.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_load_en <= 1'b0;
            r_icol    <= 2'd0;
            r_done    <= 1'b0;
        end else begin
            r_load_en <= MEM_CS;
            r_icol    <= r_idx;
            r_done    <= w_wait_end;
        end
    end

    assign LOAD_EN  = r_load_en;
    assign ICOL     = r_icol;
    assign DONE     = r_done;
    assign ODST_OUT = r_odst;

`ifdef ILOADER_BSWAP_EN
    assign IWord = {MEM_RDATA[7:0], MEM_RDATA[15:8], MEM_RDATA[23:16], MEM_RDATA[31:24]};
`else
    assign IWord = MEM_RDATA;
`endif

endmodule
`default_nettype wire
